// File: rtl/nischal_tx_pkg.sv
// Shared definitions for the Nischal serial sum transmitter tile.
//   SUM_W      : width of the operand sum (8-bit + 7-bit operands)
//   FRAME_BITS : start + SUM_W data + parity + stop
//   tx_state_e : transmitter FSM encoding
package nischal_tx_pkg;

  localparam int SUM_W      = 9;
  localparam int FRAME_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/tt_um_nischal_sum_tx_if.sv
// TinyTapeout tile pin bundle.
//   ena     : tile enable (unused by this tile)
//   ui_in   : dedicated inputs
//   uio_in  : bidirectional pins, input side
//   uo_out  : dedicated outputs
//   uio_out : bidirectional pins, output side
//   uio_oe  : bidirectional pins, output enables
// master = whatever drives the tile (harness / bench), slave = the tile.
interface tt_um_nischal_sum_tx_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/nischal_sync_edge.sv
// Two-flop synchronizer followed by a previous-value flop for rising-edge
// detection of an asynchronous level.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   rise       : one-cycle pulse when the synchronized level goes 0 -> 1
// RST_VAL sets the reset value of all three flops; resetting to 1 means an
// input already high when reset releases is not seen as a rising edge.
module nischal_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      prev  <= RST_VAL;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/tt_um_nischal_sum_tx.sv
// Serial sum transmitter: on a rising start strobe (uio_in[7]) captures
// A = ui_in and B = uio_in[6:0], and sends A+B as a 12-bit frame
// (start, sum[0..8] LSB first, even parity, stop) on uo_out[0].
//   clk, rst_n  : clock, async active-low reset
//   io.ui_in    : operand A
//   io.uio_in   : [6:0] operand B, [7] start strobe
//   io.uo_out   : [0] tx (idle high), [1] busy, [2] done pulse, [7:3] zero
//   io.uio_out  : zero
//   io.uio_oe   : zero (all uio pins are inputs)
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | line high, waiting for a start strobe
// ST_START  | start bit (0)
// ST_DATA   | sum[bit_idx], bit_idx 0..8
// ST_PARITY | even parity of the captured sum
// ST_STOP   | stop bit (1); exit raises done for one cycle
module tt_um_nischal_sum_tx
  import nischal_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tt_um_nischal_sum_tx_if.slave io
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(SUM_W - 1);

  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [SUM_W-1:0] sum, sum_in;
  logic             parity;
  logic             done;
  logic             start;
  logic             baud_tc;
  logic             capture;
  logic             done_set;
  logic             tx;
  logic             busy;
  logic             unused_ena;

  nischal_sync_edge #(.RST_VAL(1'b1)) u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io.uio_in[7]),
    .rise  (start)
  );

  assign sum_in  = {1'b0, io.ui_in} + {2'b00, io.uio_in[6:0]};
  assign baud_tc = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    busy      = 1'b1;
    capture   = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_tc) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = sum[bit_idx];
        if (baud_tc && bit_idx == IDX_LAST) state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        tx = parity;
        if (baud_tc) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tc) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter idles at 0, so the first bit after capture gets a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      sum      <= '0;
      parity   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_set;
      if (capture) begin
        sum      <= sum_in;
        parity   <= ^sum_in;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state != ST_IDLE) begin
        if (baud_tc) begin
          baud_cnt <= '0;
          if (state == ST_DATA)
            bit_idx <= (bit_idx == IDX_LAST) ? 4'd0 : bit_idx + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

  assign io.uo_out  = {5'b00000, done, busy, tx};
  assign io.uio_out = 8'h00;
  assign io.uio_oe  = 8'h00;
  assign unused_ena = io.ena;

endmodule
